aes_fsm: RTL and testbench
==========================

Name: aes_fsm

Overview:
Control-group sequencer for one AES accelerator. It accepts a job (key, text and destination addresses plus mode bits) from the request queue, arbitrates for the shared data bus, and issues bus commands in order: key load (optional), text load, result write-back. It then posts the destination address to the completion queue. It sits between the request/completion queues, the bus arbiter and the memory/accelerator data bus.

Parameters:
ADDRW, 24, address width in bits
ACCEL_ID, 2'b10, bus ID of the AES accelerator (memory ID is fixed at 2'b00)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request queue has a job
req_data  in  3*ADDRW+2  [ADDRW-1:0] key addr, [2*ADDRW-1:ADDRW] text addr, [3*ADDRW-1:2*ADDRW] dest addr, [3*ADDRW] encrypt(1)/decrypt(0), [3*ADDRW+1] key-reuse request
ready_req_out  out  1  FSM can accept a job
comq_ready_in  in  1  completion queue can accept
compq_data_out  out  ADDRW  destination address of the finished job
valid_compq_out  out  1  completion entry valid
arb_req  out  1  bus request to arbiter
arb_grant  in  1  bus granted this cycle
ack_in  in  3  [0] memory read/transfer done, [1] AES computation done, [2] memory write done
data_out  out  ADDRW+8  bus command {cmd[7:0], addr[ADDRW-1:0]}

Behaviour:
- Command byte cmd: [7:6] source ID, [5:4] destination ID, [3] key flag, [2] encrypt bit of the job, [1:0] = 0.
- States: IDLE, RD_KEY, WAIT_KEY, RD_TEXT, WAIT_TEXT, WAIT_AES, WR_RES, WAIT_WR, COMPLETE.
- Reset (async): state IDLE, all address/mode registers 0, key_valid 0. Outputs: arb_req 0, data_out 0, valid_compq_out 0, compq_data_out 0. ready_req_out is 1, since it is Moore-decoded from IDLE.
- IDLE:
  - ready_req_out = 1.
  - On req_valid, latch req_data in the same clock edge.
  - Go to RD_TEXT if the reuse bit is set and key_valid = 1; otherwise go to RD_KEY.
- RD_KEY / RD_TEXT / WR_RES (bus states):
  - arb_req = 1.
  - In the cycle arb_grant = 1, data_out carries the command combinationally, then the FSM advances.
  - data_out = 0 in every other cycle.
  - arb_grant outside bus states is ignored.
- Commands issued:
  - RD_KEY: src MEM, dst ACCEL_ID, key = 1, addr = key addr.
  - RD_TEXT: src MEM, dst ACCEL_ID, key = 0, addr = text addr.
  - WR_RES: src ACCEL_ID, dst MEM, key = 0, addr = dest addr.
- Wait states:
  - WAIT_KEY: on ack_in[0], set key_valid = 1 and go to RD_TEXT.
  - WAIT_TEXT: on ack_in[0], go to WAIT_AES.
  - WAIT_AES: on ack_in[1], go to WR_RES.
  - WAIT_WR: on ack_in[2], go to COMPLETE.
  - ack bits not matching the current state are ignored. An ack arriving in the same cycle as a grant is ignored.
- COMPLETE:
  - valid_compq_out = 1 and compq_data_out = dest addr.
  - Hold both until comq_ready_in = 1, then go to IDLE.
  - compq_data_out reads 0 outside COMPLETE.
- A new job is accepted in IDLE only; there is no pipelining.
- key_valid is cleared only by reset.
- Reset mid-job aborts immediately: back to IDLE, outputs at reset values, key_valid cleared.
- No timeouts; the FSM waits indefinitely on grant/ack.

Decomposition:
- Shared package aes_ctrl_pkg holds:
  - state enum;
  - bus IDs (MEM_ID = 2'b00);
  - cmd bit positions;
  - req_data field offsets.
- A single module is sufficient. Command formatting may go in an optional sub-module bus_cmd_fmt (IDs + flags + addr -> data_out).

Test Plan:
- Reset: rst_n = 0 mid-operation -> ready_req_out = 1, arb_req = 0, data_out = 0, valid_compq_out = 0 immediately (async).
- Full encrypt job:
  - Stimulus: ADDRW = 24, req_data = {1'b0, 1'b1, 24'h000300, 24'h000200, 24'h000100}, grants after 2 cycles, each ack 3 cycles later.
  - Expected data_out in grant cycles: 32'h2C000100, then 32'h24000200, then 32'h84000300.
  - Then valid_compq_out = 1 with compq_data_out = 24'h000300.
- Key reuse: second job with bit[73] = 1 and the same key -> no 0x2C command; first grant carries 32'h24xxxxxx. The first job after reset with reuse = 1 still loads the key.
- Decrypt job: bit[72] = 0 -> text command cmd 0x20, write command cmd 0x80.
- Backpressure: comq_ready_in = 0 for 5 cycles in COMPLETE -> valid_compq_out and compq_data_out held stable, ready_req_out = 0. Release -> IDLE next cycle.
- Spurious signals: ack_in = 3'b111 and arb_grant = 1 while in IDLE -> no state change, data_out = 0.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES control sequencer: state encoding, bus IDs,
// command byte layout and request word field positions.
package aes_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_KEY,
    WAIT_KEY,
    RD_TEXT,
    WAIT_TEXT,
    WAIT_AES,
    WR_RES,
    WAIT_WR,
    COMPLETE
  } state_t;

  localparam logic [1:0] MEM_ID = 2'b00;

  // Command byte: [7:6] src, [5:4] dst, [3] key flag, [2] encrypt, [1:0] zero
  localparam int CMD_SRC_LSB = 6;
  localparam int CMD_DST_LSB = 4;
  localparam int CMD_KEY_BIT = 3;
  localparam int CMD_ENC_BIT = 2;

  // Address fields are ADDRW wide at index*ADDRW; mode bits sit above them
  localparam int REQ_KEY_FIELD  = 0;
  localparam int REQ_TEXT_FIELD = 1;
  localparam int REQ_DEST_FIELD = 2;
  localparam int REQ_ENC_OFS    = 0;
  localparam int REQ_REUSE_OFS  = 1;

endpackage

// File: rtl/bus_cmd_fmt.sv
// Packs bus IDs, flags and an address into the {cmd, addr} bus word; drives
// zero whenever no command is being issued.
module bus_cmd_fmt
  import aes_ctrl_pkg::*;
#(
  parameter int ADDRW = 24
) (
  input  logic             en,
  input  logic [1:0]       src_id,
  input  logic [1:0]       dst_id,
  input  logic             key_flag,
  input  logic             enc,
  input  logic [ADDRW-1:0] addr,
  output logic [ADDRW+7:0] data_out
);

  logic [7:0] cmd;

  always_comb begin
    cmd                        = '0;
    cmd[CMD_SRC_LSB +: 2]      = src_id;
    cmd[CMD_DST_LSB +: 2]      = dst_id;
    cmd[CMD_KEY_BIT]           = key_flag;
    cmd[CMD_ENC_BIT]           = enc;
    data_out                   = en ? {cmd, addr} : '0;
  end

endmodule

// File: rtl/aes_fsm.sv
// AES job sequencer: takes a job from the request queue, issues key/text
// load and result write-back bus commands, then posts completion.
module aes_fsm
  import aes_ctrl_pkg::*;
#(
  parameter int         ADDRW    = 24,
  parameter logic [1:0] ACCEL_ID = 2'b10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [3*ADDRW+1:0] req_data,
  output logic               ready_req_out,
  input  logic               comq_ready_in,
  output logic [ADDRW-1:0]   compq_data_out,
  output logic               valid_compq_out,
  output logic               arb_req,
  input  logic               arb_grant,
  input  logic [2:0]         ack_in,
  output logic [ADDRW+7:0]   data_out
);

  state_t           state;
  logic [ADDRW-1:0] key_addr;
  logic [ADDRW-1:0] text_addr;
  logic [ADDRW-1:0] dest_addr;
  logic             enc;
  logic             key_valid;

  logic             req_reuse;
  logic             bus_state;
  logic             cmd_en;
  logic [1:0]       cmd_src;
  logic [1:0]       cmd_dst;
  logic             cmd_key;
  logic [ADDRW-1:0] cmd_addr;

  assign req_reuse = req_data[3*ADDRW + REQ_REUSE_OFS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_addr  <= '0;
      text_addr <= '0;
      dest_addr <= '0;
      enc       <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            key_addr  <= req_data[REQ_KEY_FIELD*ADDRW  +: ADDRW];
            text_addr <= req_data[REQ_TEXT_FIELD*ADDRW +: ADDRW];
            dest_addr <= req_data[REQ_DEST_FIELD*ADDRW +: ADDRW];
            enc       <= req_data[3*ADDRW + REQ_ENC_OFS];
            state     <= (req_reuse && key_valid) ? RD_TEXT : RD_KEY;
          end
        end
        RD_KEY:    if (arb_grant) state <= WAIT_KEY;
        WAIT_KEY: begin
          if (ack_in[0]) begin
            key_valid <= 1'b1;
            state     <= RD_TEXT;
          end
        end
        RD_TEXT:   if (arb_grant)     state <= WAIT_TEXT;
        WAIT_TEXT: if (ack_in[0])     state <= WAIT_AES;
        WAIT_AES:  if (ack_in[1])     state <= WR_RES;
        WR_RES:    if (arb_grant)     state <= WAIT_WR;
        WAIT_WR:   if (ack_in[2])     state <= COMPLETE;
        COMPLETE:  if (comq_ready_in) state <= IDLE;
        default:                      state <= IDLE;
      endcase
    end
  end

  // Moore-decoded handshake outputs; only the bus word depends on the grant
  assign ready_req_out   = (state == IDLE);
  assign valid_compq_out = (state == COMPLETE);
  assign compq_data_out  = (state == COMPLETE) ? dest_addr : '0;
  assign bus_state       = (state == RD_KEY) || (state == RD_TEXT) || (state == WR_RES);
  assign arb_req         = bus_state;
  assign cmd_en          = bus_state && arb_grant;

  always_comb begin
    cmd_src  = MEM_ID;
    cmd_dst  = ACCEL_ID;
    cmd_key  = 1'b0;
    cmd_addr = text_addr;
    unique case (state)
      RD_KEY: begin
        cmd_key  = 1'b1;
        cmd_addr = key_addr;
      end
      WR_RES: begin
        cmd_src  = ACCEL_ID;
        cmd_dst  = MEM_ID;
        cmd_addr = dest_addr;
      end
      default: ;
    endcase
  end

  bus_cmd_fmt #(
    .ADDRW(ADDRW)
  ) u_fmt (
    .en       (cmd_en),
    .src_id   (cmd_src),
    .dst_id   (cmd_dst),
    .key_flag (cmd_key),
    .enc      (enc),
    .addr     (cmd_addr),
    .data_out (data_out)
  );

endmodule

// File: tb/tb_aes_fsm.sv
// Directed bench for aes_fsm: full jobs, key reuse, decrypt, backpressure,
// spurious inputs and asynchronous reset.
module tb_aes_fsm;

  localparam int ADDRW = 24;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic [3*ADDRW+1:0] req_data;
  logic               ready_req_out;
  logic               comq_ready_in;
  logic [ADDRW-1:0]   compq_data_out;
  logic               valid_compq_out;
  logic               arb_req;
  logic               arb_grant;
  logic [2:0]         ack_in;
  logic [ADDRW+7:0]   data_out;

  int checks = 0;
  int errors = 0;

  aes_fsm #(.ADDRW(ADDRW), .ACCEL_ID(2'b10)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .ready_req_out   (ready_req_out),
    .comq_ready_in   (comq_ready_in),
    .compq_data_out  (compq_data_out),
    .valid_compq_out (valid_compq_out),
    .arb_req         (arb_req),
    .arb_grant       (arb_grant),
    .ack_in          (ack_in),
    .data_out        (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Two idle cycles of arbitration, then a grant carrying the command;
  // a simultaneous all-ones ack must not advance the following wait state.
  task automatic bus_phase(input string tag, input logic [31:0] exp);
    repeat (2) begin
      chk({tag, "_req"}, arb_req, 1'b1);
      chk({tag, "_idle_bus"}, data_out, 32'h0);
      @(negedge clk);
    end
    arb_grant = 1'b1;
    ack_in    = 3'b111;
    #1 chk({tag, "_cmd"}, data_out, exp);
    @(negedge clk);
    arb_grant = 1'b0;
    ack_in    = 3'b000;
    chk({tag, "_req_drop"}, arb_req, 1'b0);
  endtask

  // First wait cycle carries non-matching ack bits, the correct bit arrives 3 cycles in
  task automatic ack_phase(input int idx, input logic [2:0] noise);
    ack_in = noise;
    @(negedge clk);
    ack_in = 3'b000;
    @(negedge clk);
    ack_in[idx] = 1'b1;
    @(negedge clk);
    ack_in = 3'b000;
  endtask

  task automatic run_job(input string tag, input logic [23:0] ka, input logic [23:0] ta,
                         input logic [23:0] da, input logic en, input logic reuse,
                         input logic has_key, input logic [31:0] key_cmd,
                         input logic [31:0] text_cmd, input logic [31:0] wr_cmd, input int bp);
    chk({tag, "_ready"}, ready_req_out, 1'b1);
    req_valid = 1'b1;
    req_data  = {reuse, en, da, ta, ka};
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = '0;
    chk({tag, "_busy"}, ready_req_out, 1'b0);
    if (has_key) begin
      bus_phase({tag, "_key"}, key_cmd);
      ack_phase(0, 3'b110);
    end
    bus_phase({tag, "_text"}, text_cmd);
    ack_phase(0, 3'b110);
    ack_phase(1, 3'b101);
    bus_phase({tag, "_wr"}, wr_cmd);
    ack_phase(2, 3'b011);
    for (int i = 0; i < bp; i++) begin
      chk({tag, "_bp_valid"}, valid_compq_out, 1'b1);
      chk({tag, "_bp_data"}, compq_data_out, da);
      chk({tag, "_bp_ready"}, ready_req_out, 1'b0);
      @(negedge clk);
    end
    chk({tag, "_cq_valid"}, valid_compq_out, 1'b1);
    chk({tag, "_cq_data"}, compq_data_out, da);
    comq_ready_in = 1'b1;
    @(negedge clk);
    comq_ready_in = 1'b0;
    chk({tag, "_back_idle"}, ready_req_out, 1'b1);
    chk({tag, "_cq_clear"}, valid_compq_out, 1'b0);
    chk({tag, "_cq_data0"}, compq_data_out, 24'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_data = '0;
    comq_ready_in = 1'b0;
    arb_grant = 1'b0;
    ack_in = 3'b000;
    #1;
    chk("rst_ready", ready_req_out, 1'b1);
    chk("rst_arb", arb_req, 1'b0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_cq_valid", valid_compq_out, 1'b0);
    chk("rst_cq_data", compq_data_out, 24'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Spurious grant/ack while idle
    arb_grant = 1'b1;
    ack_in    = 3'b111;
    #1 chk("spur_data", data_out, 32'h0);
    chk("spur_arb", arb_req, 1'b0);
    @(negedge clk);
    arb_grant = 1'b0;
    ack_in    = 3'b000;
    chk("spur_idle", ready_req_out, 1'b1);
    chk("spur_arb2", arb_req, 1'b0);

    run_job("enc", 24'h000100, 24'h000200, 24'h000300, 1'b1, 1'b0, 1'b1,
            32'h2C000100, 32'h24000200, 32'h84000300, 5);
    run_job("reuse", 24'h000100, 24'h000210, 24'h000310, 1'b1, 1'b1, 1'b0,
            32'h0, 32'h24000210, 32'h84000310, 0);
    run_job("dec", 24'h000100, 24'h000220, 24'h000320, 1'b0, 1'b1, 1'b0,
            32'h0, 32'h20000220, 32'h80000320, 1);

    // Abort a job mid-arbitration with an asynchronous reset
    req_valid = 1'b1;
    req_data  = {1'b0, 1'b1, 24'h000333, 24'h000222, 24'h000111};
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_arb", arb_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready_req_out, 1'b1);
    chk("abort_arb0", arb_req, 1'b0);
    chk("abort_data", data_out, 32'h0);
    chk("abort_cq", valid_compq_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // key_valid was cleared by reset, so reuse must still load the key
    run_job("post_rst", 24'h000100, 24'h000200, 24'h000300, 1'b1, 1'b1, 1'b1,
            32'h2C000100, 32'h24000200, 32'h84000300, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
